// File: rtl/sdm_pkg.sv
// Shared constants for the 2nd-order sigma-delta modulator: default widths, full-scale
// feedback level, integrator saturation limits, mute FSM encoding and dither LFSR setup.
package sdm_pkg;
    localparam int DW_DEF        = 24;
    localparam int IW_DEF        = DW_DEF + 4;
    localparam int GW_DEF        = 10;
    localparam int RAMP_STEP_DEF = 1;

    localparam longint FS    = 64'sd1 <<< (DW_DEF - 1);
    localparam longint I_MAX = (64'sd1 <<< (IW_DEF - 1)) - 1;
    localparam longint I_MIN = -I_MAX;

    typedef enum logic [1:0] {
        MUTED   = 2'd0,
        RAMP_UP = 2'd1,
        UNITY   = 2'd2,
        RAMP_DN = 2'd3
    } mute_state_t;

    // x^16+x^14+x^13+x^11+1 as a right-shifting Fibonacci register: feedback taps bits 0,2,3,5
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;
endpackage

// File: rtl/sdm_mute_ramp.sv
// Soft-mute controller: walks the gain one RAMP_STEP per clock toward 0 or unity,
// with mute_ack registered high exactly while the FSM sits in MUTED.
module sdm_mute_ramp
    import sdm_pkg::*;
#(
    parameter int GW        = GW_DEF,
    parameter int RAMP_STEP = RAMP_STEP_DEF
) (
    input  logic        clock,
    input  logic        rstn,
    input  logic        mute_req,
    output logic [GW:0] gain,
    output logic        mute_ack
);
    localparam logic [GW:0] G_MAX = {1'b1, {GW{1'b0}}};
    localparam logic [GW:0] STEP  = (GW+1)'(RAMP_STEP);

    mute_state_t state, state_n;
    logic [GW:0] gain_n, gain_up, gain_dn;

    assign gain_up = (gain >= G_MAX - STEP) ? G_MAX : gain + STEP;
    assign gain_dn = (gain <= STEP) ? '0 : gain - STEP;

    always_comb begin
        state_n = state;
        gain_n  = gain;
        case (state)
            MUTED:   if (!mute_req) state_n = RAMP_UP;
            RAMP_UP: if (mute_req)  state_n = RAMP_DN;
            UNITY:   if (mute_req)  state_n = RAMP_DN;
            RAMP_DN: if (!mute_req) state_n = RAMP_UP;
            default: state_n = MUTED;
        endcase
        // The step is taken on the same edge the direction is decided, so reversals
        // continue from the current gain and a full ramp lasts 2**GW/RAMP_STEP clocks.
        if (state_n == RAMP_UP) begin
            gain_n = gain_up;
            if (gain_up == G_MAX) state_n = UNITY;
        end else if (state_n == RAMP_DN) begin
            gain_n = gain_dn;
            if (gain_dn == '0) state_n = MUTED;
        end else if (state_n == UNITY) begin
            gain_n = G_MAX;
        end else begin
            gain_n = '0;
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state    <= MUTED;
            gain     <= '0;
            mute_ack <= 1'b1;
        end else begin
            state    <= state_n;
            gain     <= gain_n;
            mute_ack <= (state_n == MUTED);
        end
    end
endmodule

// File: rtl/sdm_2nd_order_mod.sv
// Second-order 1-bit sigma-delta modulator with soft-mute gain ramp, saturating
// integrators and sticky overflow flag. Define SDM_DITHER_EN to add LFSR dither to q.
module sdm_2nd_order_mod
    import sdm_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int IW        = IW_DEF,
    parameter int GW        = GW_DEF,
    parameter int RAMP_STEP = RAMP_STEP_DEF
) (
    input  logic                 clock,
    input  logic                 rstn,
    input  logic signed [DW-1:0] data_in,
    input  logic                 mute_req,
    input  logic                 ovf_clr,
    output logic                 sdm_out,
    output logic                 mute_ack,
    output logic                 ovf_flag
);
    localparam int SW = IW + 2;
    localparam int PW = DW + GW + 2;
    localparam logic signed [SW-1:0] FS_S   = {{(SW-DW){1'b0}}, 1'b1, {(DW-1){1'b0}}};
    localparam logic signed [SW-1:0] SAT_HI = {{(SW-IW+1){1'b0}}, {(IW-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_LO = -SAT_HI;
    localparam logic signed [SW-1:0] ZERO   = '0;

    logic [GW:0]           gain;
    logic signed [IW-1:0]  i1, i2, i1_next, i2_next;
    logic signed [PW-1:0]  prod, x_full;
    logic signed [SW-1:0]  x, fb, s1, s2, q;
    logic                  clip1, clip2;

    sdm_mute_ramp #(.GW(GW), .RAMP_STEP(RAMP_STEP)) u_ramp (
        .clock    (clock),
        .rstn     (rstn),
        .mute_req (mute_req),
        .gain     (gain),
        .mute_ack (mute_ack)
    );

    // Gain then an extra >>>1 for -6 dB loop headroom, folded into one arithmetic shift
    assign prod   = PW'(data_in) * PW'($signed({1'b0, gain}));
    assign x_full = prod >>> (GW + 1);
    assign x      = SW'(x_full);
    assign fb     = sdm_out ? FS_S : -FS_S;

    always_comb begin
        s1      = SW'(i1) + x - fb;
        clip1   = (s1 > SAT_HI) || (s1 < SAT_LO);
        i1_next = (s1 > SAT_HI) ? IW'(SAT_HI) : (s1 < SAT_LO) ? IW'(SAT_LO) : IW'(s1);
        s2      = SW'(i2) + SW'(i1_next) - fb;
        clip2   = (s2 > SAT_HI) || (s2 < SAT_LO);
        i2_next = (s2 > SAT_HI) ? IW'(SAT_HI) : (s2 < SAT_LO) ? IW'(SAT_LO) : IW'(s2);
    end

`ifdef SDM_DITHER_EN
    logic [15:0] lfsr;

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) lfsr <= LFSR_SEED;
        else       lfsr <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
    end

    // Dither only perturbs the decision; the stored i2 stays clean
    assign q = SW'(i2_next) + SW'($signed(lfsr[3:0]));
`else
    assign q = SW'(i2_next);
`endif

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            i1       <= '0;
            i2       <= '0;
            sdm_out  <= 1'b0;
            ovf_flag <= 1'b0;
        end else begin
            i1       <= i1_next;
            i2       <= i2_next;
            sdm_out  <= (q >= ZERO);
            ovf_flag <= clip1 | clip2 | (ovf_flag & ~ovf_clr);
        end
    end
endmodule

// File: tb/tb_sdm_2nd_order_mod.sv
// Randomized bench for sdm_2nd_order_mod against an integer-arithmetic loop model,
// plus density and mute-timing checks taken directly from the modulator's behaviour.
module tb_sdm_2nd_order_mod;
    import sdm_pkg::*;

    localparam longint FSV  = 64'sd8388608;
    localparam longint IMAX = 64'sd134217727;

    logic              clock    = 1'b0;
    logic              rstn     = 1'b0;
    logic signed [23:0] data_in = '0;
    logic              mute_req = 1'b1;
    logic              ovf_clr  = 1'b0;
    logic              sdm_out, mute_ack, ovf_flag;

    int     n_chk = 0, n_pass = 0;
    longint m_i1, m_i2;
    bit     m_y, m_ack, m_ovf;
    int     m_g;

    always #5 clock = ~clock;

    sdm_2nd_order_mod dut (
        .clock    (clock),
        .rstn     (rstn),
        .data_in  (data_in),
        .mute_req (mute_req),
        .ovf_clr  (ovf_clr),
        .sdm_out  (sdm_out),
        .mute_ack (mute_ack),
        .ovf_flag (ovf_flag)
    );

    function automatic void model_reset();
        m_i1 = 0; m_i2 = 0; m_y = 1'b0; m_g = 0; m_ack = 1'b1; m_ovf = 1'b0;
    endfunction

    // y tracks x with shaped error: integrate, clamp, decide on the sign of the 2nd sum
    function automatic void model_edge();
        longint x, fb, a, b;
        bit clip;
        clip = 1'b0;
        x  = (longint'(data_in) * longint'(m_g)) >>> 11;
        fb = m_y ? FSV : -FSV;
        a  = m_i1 + x - fb;
        if (a > IMAX) begin a = IMAX; clip = 1'b1; end
        else if (a < -IMAX) begin a = -IMAX; clip = 1'b1; end
        b  = m_i2 + a - fb;
        if (b > IMAX) begin b = IMAX; clip = 1'b1; end
        else if (b < -IMAX) begin b = -IMAX; clip = 1'b1; end
        m_i1  = a;
        m_i2  = b;
        m_y   = (b >= 0);
        m_ovf = clip || (m_ovf && !ovf_clr);
        if (mute_req) m_g = (m_g > 0) ? m_g - 1 : 0;
        else          m_g = (m_g < 1024) ? m_g + 1 : 1024;
        m_ack = (m_g == 0);
    endfunction

    function automatic logic [58:0] obs();
        return {sdm_out, mute_ack, ovf_flag, dut.i1, dut.i2};
    endfunction

    function automatic logic [58:0] expv();
        return {m_y, m_ack, m_ovf, m_i1[27:0], m_i2[27:0]};
    endfunction

    task automatic step();
        @(posedge clock);
        if (rstn) model_edge();
        #1;
    endtask

    task automatic test_reset();
        mute_req = 1'b0;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            data_in = 24'($urandom);
            step();
        end
        n_chk++;
        if (obs() !== expv()) $display("FAIL reset_state: got %h want %h", obs(), expv());
        else n_pass++;
        n_chk++;
        if (dut.gain !== 11'd0) $display("FAIL reset_gain: got %0d want 0", dut.gain);
        else n_pass++;
    endtask

    task automatic test_ramp_up();
        rstn = 1'b1;
        n_chk++;
        if (mute_ack !== 1'b1) $display("FAIL release_ack: got %b want 1", mute_ack);
        else n_pass++;
        for (int k = 1; k <= 1024; k++) begin
            data_in = 24'($urandom);
            step();
            n_chk++;
            if (obs() !== expv()) $display("FAIL ramp_up cyc %0d: got %h want %h", k, obs(), expv());
            else n_pass++;
            if (k == 1) begin
                n_chk++;
                if (mute_ack !== 1'b0) $display("FAIL ramp_ack_drop: got %b want 0", mute_ack);
                else n_pass++;
            end
            if (k == 1023 || k == 1024) begin
                n_chk++;
                if (dut.gain !== 11'(k)) $display("FAIL ramp_gain cyc %0d: got %0d want %0d", k, dut.gain, k);
                else n_pass++;
            end
        end
        n_chk++;
        if (dut.u_ramp.state !== UNITY) $display("FAIL ramp_unity: got %0d want %0d", dut.u_ramp.state, UNITY);
        else n_pass++;
    endtask

    task automatic test_density(input string name, input logic signed [23:0] d,
                                input int win, input int nwin, input int lo, input int hi);
        int ones;
        data_in = d;
        for (int k = 0; k < 256; k++) begin
            step();
            n_chk++;
            if (obs() !== expv()) $display("FAIL %s settle cyc %0d: got %h want %h", name, k, obs(), expv());
            else n_pass++;
        end
        for (int w = 0; w < nwin; w++) begin
            ones = 0;
            for (int k = 0; k < win; k++) begin
                step();
                ones += int'(sdm_out);
                n_chk++;
                if (obs() !== expv()) $display("FAIL %s cyc %0d: got %h want %h", name, k, obs(), expv());
                else n_pass++;
            end
            n_chk++;
            if (ones < lo || ones > hi) $display("FAIL %s ones win %0d: got %0d want %0d..%0d", name, w, ones, lo, hi);
            else n_pass++;
        end
    endtask

    task automatic test_mute_midramp();
        mute_req = 1'b1;
        for (int k = 0; k < 1024; k++) begin
            data_in = 24'($urandom);
            step();
            n_chk++;
            if (obs() !== expv()) $display("FAIL mute_full cyc %0d: got %h want %h", k, obs(), expv());
            else n_pass++;
        end
        mute_req = 1'b0;
        for (int k = 0; k < 512; k++) begin
            data_in = 24'($urandom);
            step();
            n_chk++;
            if (obs() !== expv()) $display("FAIL mid_up cyc %0d: got %h want %h", k, obs(), expv());
            else n_pass++;
        end
        n_chk++;
        if (dut.gain !== 11'd512) $display("FAIL mid_gain: got %0d want 512", dut.gain);
        else n_pass++;
        mute_req = 1'b1;
        for (int k = 1; k <= 512; k++) begin
            data_in = 24'($urandom);
            step();
            n_chk++;
            if (obs() !== expv()) $display("FAIL mid_dn cyc %0d: got %h want %h", k, obs(), expv());
            else n_pass++;
            if (k == 1) begin
                n_chk++;
                if (dut.u_ramp.state !== RAMP_DN || dut.gain !== 11'd511)
                    $display("FAIL mid_reverse: got st %0d g %0d want st %0d g 511", dut.u_ramp.state, dut.gain, RAMP_DN);
                else n_pass++;
            end
            if (k == 511 || k == 512) begin
                n_chk++;
                if (mute_ack !== (k == 512)) $display("FAIL mid_ack cyc %0d: got %b want %b", k, mute_ack, k == 512);
                else n_pass++;
            end
        end
        test_density("mute_density", 24'sh5A5A5A, 256, 1, 126, 130);
    endtask

    task automatic test_full_scale();
        mute_req = 1'b0;
        for (int k = 0; k < 1024; k++) begin
            data_in = 24'($urandom);
            step();
        end
        n_chk++;
        if (obs() !== expv()) $display("FAIL fs_ramp: got %h want %h", obs(), expv());
        else n_pass++;
        for (int k = 0; k < 1024; k++) begin
            data_in = ((k / 64) % 2 == 0) ? 24'sh7FFFFF : -24'sh7FFFFF;
            ovf_clr = ($urandom_range(0, 7) == 0);
            step();
            n_chk++;
            if (obs() !== expv()) $display("FAIL full_scale cyc %0d: got %h want %h", k, obs(), expv());
            else n_pass++;
        end
        ovf_clr = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 2000; k++) begin
            data_in = 24'($urandom);
            if ($urandom_range(0, 299) == 0) mute_req = ~mute_req;
            ovf_clr = ($urandom_range(0, 15) == 0);
            step();
            n_chk++;
            if (obs() !== expv()) $display("FAIL b2b cyc %0d: got %h want %h", k, obs(), expv());
            else n_pass++;
        end
        ovf_clr = 1'b0;
    endtask

    task automatic test_reset_midramp();
        mute_req = 1'b0;
        for (int k = 0; k < 1100; k++) begin data_in = 24'($urandom); step(); end
        mute_req = 1'b1;
        for (int k = 0; k < 300; k++) begin data_in = 24'($urandom); step(); end
        n_chk++;
        if (obs() !== expv() || dut.u_ramp.state !== RAMP_DN)
            $display("FAIL pre_reset: got %h st %0d want %h st %0d", obs(), dut.u_ramp.state, expv(), RAMP_DN);
        else n_pass++;
        rstn = 1'b0;
        model_reset();
        #1;
        n_chk++;
        if (obs() !== expv() || dut.gain !== 11'd0) $display("FAIL async_reset: got %h g %0d want %h g 0", obs(), dut.gain, expv());
        else n_pass++;
        step();
        n_chk++;
        if (obs() !== expv() || dut.gain !== 11'd0) $display("FAIL reset_edge: got %h g %0d want %h g 0", obs(), dut.gain, expv());
        else n_pass++;
        rstn = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k == 8) mute_req = 1'b0;
            data_in = 24'($urandom);
            step();
            n_chk++;
            if (obs() !== expv() || dut.gain !== 11'(m_g))
                $display("FAIL post_reset cyc %0d: got %h g %0d want %h g %0d", k, obs(), dut.gain, expv(), m_g);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_density("idle_density", 24'sd0, 256, 4, 126, 130);
        test_density("dc_density", 24'sd2097152, 1024, 1, 572, 580);
        test_mute_midramp();
        test_full_scale();
        test_back_to_back();
        test_reset_midramp();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
